nor_tree_pipe: RTL and testbench

Parametrised, pipelined N-input reduction gate: the clocked successor to the fixed three-input NOR cell. Reduces a WIDTH-bit input vector through a tree of FANIN-input stages, one register level per stage, with a per-transaction mode select (NOR/OR/NAND/AND), valid tracking and a global stall. Used wherever a wide NOR/AND-type flag must be formed at clock rate without a long combinational path.

---
 rtl/nor_tree_pipe.sv | 141 ++++++++++++++
 tb/tb_nor_tree_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_tree_pipe.sv
// Pipelined WIDTH-input NOR/OR/NAND/AND reduction tree, one register level per FANIN-input stage.
// Optional saturating result counter (CLR/CNT) enabled by defining NOR_TREE_CNT_EN.
module nor_tree_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned FANIN = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [1:0]       mode_i,
  input  logic             vi_i,
  input  logic             en_i,
`ifdef NOR_TREE_CNT_EN
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             y_o,
  output logic             vo_o
);

  function automatic int unsigned ceil_div(input int unsigned n);
    return (n + FANIN - 1) / FANIN;
  endfunction

  function automatic int unsigned nodes_at(input int unsigned lvl);
    int unsigned n;
    n = WIDTH;
    for (int unsigned i = 0; i < lvl; i++) n = ceil_div(n);
    return n;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned n;
    int unsigned l;
    n = WIDTH;
    l = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = ceil_div(n);
        l = l + 1;
      end
    end
    return (l == 0) ? 1 : l;
  endfunction

  localparam int unsigned LEVELS = num_levels();

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NIN  = nodes_at(k);
    localparam int unsigned NOUT = nodes_at(k + 1);
    localparam int unsigned PADW = NOUT * FANIN;
    localparam bit          LAST = (k == LEVELS - 1);

    logic [NIN-1:0]  in_w;
    logic [1:0]      mode_w;
    logic            vld_w;
    logic [PADW-1:0] pad_c;
    logic [NOUT-1:0] node_d;
    logic [NOUT-1:0] node_q;
    logic            vld_q;

    if (k == 0) begin : g_src
      assign in_w   = a_i;
      assign mode_w = mode_i;
      assign vld_w  = vi_i;
    end else begin : g_src
      assign in_w   = g_lvl[k-1].node_q;
      assign mode_w = g_lvl[k-1].g_fwd.mode_q;
      assign vld_w  = g_lvl[k-1].vld_q;
    end

    // Partial groups are filled with the identity of the active function (1 for AND, 0 for OR)
    always_comb begin
      pad_c            = {PADW{mode_w[1]}};
      pad_c[NIN-1:0]   = in_w;
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_node
      logic [FANIN-1:0] grp;
      logic             red;
      assign grp       = pad_c[j*FANIN +: FANIN];
      assign red       = mode_w[1] ? (&grp) : (|grp);
      assign node_d[j] = (LAST && !mode_w[0]) ? ~red : red;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        node_q <= '0;
        vld_q  <= 1'b0;
      end else if (en_i) begin
        node_q <= node_d;
        vld_q  <= vld_w;
      end
    end

    // Mode only needs to travel on to a following level
    if (!LAST) begin : g_fwd
      logic [1:0] mode_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mode_q <= 2'b00;
        end else if (en_i) begin
          mode_q <= mode_w;
        end
      end
    end
  end

  assign y_o  = g_lvl[LEVELS-1].node_q[0];
  assign vo_o = g_lvl[LEVELS-1].vld_q;

`ifdef NOR_TREE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             inc_c;

  assign inc_c = en_i & g_lvl[LEVELS-1].vld_w & g_lvl[LEVELS-1].node_d[0];

  // Clear wins over a simultaneous increment and does not depend on EN
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Self-checking bench for nor_tree_pipe: several tree shapes share one stimulus stream and are
// compared against a transaction-history reference model; counter checks need NOR_TREE_CNT_EN.
module tb_nor_tree_pipe;

  typedef struct {
    logic [26:0] a;
    logic [1:0]  mode;
    logic        vi;
  } txn_t;

  typedef struct {
    logic [2:0] a;
    logic [1:0] m;
    logic       y;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [26:0] a;
  logic [1:0]  mode;
  logic        vi;
  logic        en;
  logic        clr;

  logic y3, vo3, y10, vo10, y8, vo8, y1, vo1, y16, vo16, y27, vo27, y10b, vo10b;
  logic [1:0]  cnt3;
  logic [15:0] cnt10, cnt8, cnt1, cnt16, cnt27, cnt10b;

  txn_t hist[$];
  int   n_chk;
  int   n_pass;

  nor_tree_pipe #(.WIDTH(3), .FANIN(3), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .a_i(a[2:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt3),
`endif
    .y_o(y3), .vo_o(vo3));

  nor_tree_pipe #(.WIDTH(10), .FANIN(3)) u10 (
    .clk(clk), .rst_n(rst_n), .a_i(a[9:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt10),
`endif
    .y_o(y10), .vo_o(vo10));

  nor_tree_pipe #(.WIDTH(8), .FANIN(3)) u8 (
    .clk(clk), .rst_n(rst_n), .a_i(a[7:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt8),
`endif
    .y_o(y8), .vo_o(vo8));

  nor_tree_pipe #(.WIDTH(1), .FANIN(2)) u1 (
    .clk(clk), .rst_n(rst_n), .a_i(a[0:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt1),
`endif
    .y_o(y1), .vo_o(vo1));

  nor_tree_pipe #(.WIDTH(16), .FANIN(4)) u16 (
    .clk(clk), .rst_n(rst_n), .a_i(a[15:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt16),
`endif
    .y_o(y16), .vo_o(vo16));

  nor_tree_pipe #(.WIDTH(27), .FANIN(3)) u27 (
    .clk(clk), .rst_n(rst_n), .a_i(a[26:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt27),
`endif
    .y_o(y27), .vo_o(vo27));

  nor_tree_pipe #(.WIDTH(10), .FANIN(2)) u10b (
    .clk(clk), .rst_n(rst_n), .a_i(a[9:0]), .mode_i(mode), .vi_i(vi), .en_i(en),
`ifdef NOR_TREE_CNT_EN
    .clr_i(clr), .cnt_o(cnt10b),
`endif
    .y_o(y10b), .vo_o(vo10b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reduction defined arithmetically on the masked input word
  function automatic logic ref_y(input logic [26:0] av, input int w, input logic [1:0] m);
    logic [26:0] mask;
    logic [26:0] bits;
    logic        r;
    mask = (w >= 27) ? {27{1'b1}} : 27'((64'd1 << w) - 64'd1);
    bits = av & mask;
    if (m[1]) r = (bits == mask);
    else      r = (bits != 27'd0);
    if (!m[0]) r = ~r;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Output after an EN edge is the transaction pushed L EN-edges ago
  task automatic chk_inst(input string nm, input int lv, input int w, input logic y, input logic vo);
    txn_t e;
    logic ev;
    ev = 1'b0;
    if (hist.size() >= lv) begin
      e  = hist[hist.size() - lv];
      ev = e.vi;
    end
    chk({nm, "_vo"}, 32'(vo), 32'(ev));
    if (ev) chk({nm, "_y"}, 32'(y), 32'(ref_y(e.a, w, e.mode)));
  endtask

  task automatic check_all();
    chk_inst("w3",   1, 3,  y3,   vo3);
    chk_inst("w10",  3, 10, y10,  vo10);
    chk_inst("w8",   2, 8,  y8,   vo8);
    chk_inst("w1",   1, 1,  y1,   vo1);
    chk_inst("w16",  2, 16, y16,  vo16);
    chk_inst("w27",  3, 27, y27,  vo27);
    chk_inst("w10b", 4, 10, y10b, vo10b);
  endtask

  task automatic check_zero();
    chk("rst_y",  32'({y3, y10, y8, y1, y16, y27, y10b}), 32'd0);
    chk("rst_vo", 32'({vo3, vo10, vo8, vo1, vo16, vo27, vo10b}), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && en) begin
      hist.push_back('{a: a, mode: mode, vi: vi});
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    check_zero();
    step();
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  logic y_seq[4];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    a      = '0;
    mode   = 2'b00;
    vi     = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;

    for (int i = 0; i < 8; i++) tbl[i] = '{a: 3'(i), m: 2'b00, y: (i == 0)};
    tbl[8]  = '{a: 3'b000, m: 2'b01, y: 1'b0};
    tbl[9]  = '{a: 3'b100, m: 2'b01, y: 1'b1};
    tbl[10] = '{a: 3'b111, m: 2'b10, y: 1'b0};
    tbl[11] = '{a: 3'b111, m: 2'b11, y: 1'b1};
    tbl[12] = '{a: 3'b011, m: 2'b10, y: 1'b1};
    y_seq   = '{1'b1, 1'b0, 1'b1, 1'b1};

    do_reset();

    // WIDTH=3 single-level table
    en = 1'b1;
    vi = 1'b1;
    for (int i = 0; i < 13; i++) begin
      a    = 27'(tbl[i].a);
      mode = tbl[i].m;
      step();
      chk("w3_tbl_y",  32'(y3),  32'(tbl[i].y));
      chk("w3_tbl_vo", 32'(vo3), 32'd1);
    end

    // WIDTH=10 back-to-back mixed modes, L=3
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vi = (i < 4);
      case (i)
        0:       begin a = 27'h000; mode = 2'b00; end
        1:       begin a = 27'h200; mode = 2'b00; end
        2:       begin a = 27'h3FF; mode = 2'b11; end
        3:       begin a = 27'h3FE; mode = 2'b10; end
        default: begin a = 27'h155; mode = 2'b01; end
      endcase
      step();
      chk("w10_seq_vo", 32'(vo10), 32'((i >= 2) && (i < 6)));
      if ((i >= 2) && (i < 6)) chk("w10_seq_y", 32'(y10), 32'(y_seq[i-2]));
    end

    // WIDTH=8 stall: result waits for the second EN edge, then holds
    do_reset();
    a    = 27'h0FF;
    mode = 2'b11;
    vi   = 1'b1;
    en   = 1'b1;
    step();
    chk("w8_stall_vo0", 32'(vo8), 32'd0);
    vi = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w8_stall_vo", 32'(vo8), 32'd0);
    end
    en = 1'b1;
    step();
    chk("w8_out_y",  32'(y8),  32'd1);
    chk("w8_out_vo", 32'(vo8), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w8_hold", 32'({y8, vo8}), 32'b11);
    end

    // Reset mid-stream with two WIDTH=10 transactions in flight
    en = 1'b1;
    vi = 1'b1;
    mode = 2'b00;
    a = 27'h000;
    step();
    a = 27'h001;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    chk("w10_rst_y",  32'(y10),  32'd0);
    chk("w10_rst_vo", 32'(vo10), 32'd0);
    step();
    rst_n = 1'b1;
    vi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w10_no_stale", 32'(vo10), 32'd0);
    end
    vi = 1'b1;
    a  = 27'h000;
    step();
    vi = 1'b0;
    step();
    step();
    chk("w10_post_rst", 32'({y10, vo10}), 32'b11);

    // WIDTH=1 degenerate tree
    vi = 1'b1;
    mode = 2'b10;
    a = 27'h1;
    step();
    chk("w1_nand", 32'({y1, vo1}), 32'b01);
    mode = 2'b01;
    a = 27'h0;
    step();
    chk("w1_or", 32'({y1, vo1}), 32'b01);
    vi = 1'b0;
    step();
    chk("w1_idle_vo", 32'(vo1), 32'd0);

`ifdef NOR_TREE_CNT_EN
    do_reset();
    chk("cnt_rst", 32'(cnt3), 32'd0);
    en = 1'b1;
    vi = 1'b1;
    mode = 2'b00;
    a = 27'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cnt_sat", 32'(cnt3), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    clr = 1'b1;
    step();
    chk("cnt_clr_inc", 32'(cnt3), 32'd0);
    clr = 1'b0;
    step();
    chk("cnt_after_clr", 32'(cnt3), 32'd1);
    en = 1'b0;
    clr = 1'b1;
    step();
    chk("cnt_clr_noen", 32'(cnt3), 32'd0);
    clr = 1'b0;
`endif

    // Random traffic against the history model
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      a    = 27'($urandom);
      if ($urandom_range(0, 3) == 0) a = (27'h7FFFFFF ^ (27'd1 << $urandom_range(0, 26)));
      mode = 2'($urandom_range(0, 3));
      vi   = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
